// File: rtl/nvdla_cacc_abuf_banked_if.sv
// Assembly-buffer access bundle: write port, read port, clear control and status.
interface nvdla_cacc_abuf_banked_if #(
    parameter int unsigned DATA_W = 544,
    parameter int unsigned AW     = 6
);
    logic              abuf_wr_en;
    logic [AW-1:0]     abuf_wr_addr;
    logic [DATA_W-1:0] abuf_wr_data;
    logic              abuf_rd_en;
    logic [AW-1:0]     abuf_rd_addr;
    logic              abuf_clr_req;
    logic [31:0]       pwrbus_ram_pd;
    logic [DATA_W-1:0] abuf_rd_data;
    logic              abuf_rd_vld;
    logic              abuf_clr_busy;
    logic              abuf_drop_err;

    modport slave (
        input  abuf_wr_en, abuf_wr_addr, abuf_wr_data,
        input  abuf_rd_en, abuf_rd_addr, abuf_clr_req, pwrbus_ram_pd,
        output abuf_rd_data, abuf_rd_vld, abuf_clr_busy, abuf_drop_err
    );

    modport master (
        output abuf_wr_en, abuf_wr_addr, abuf_wr_data,
        output abuf_rd_en, abuf_rd_addr, abuf_clr_req, pwrbus_ram_pd,
        input  abuf_rd_data, abuf_rd_vld, abuf_clr_busy, abuf_drop_err
    );
endinterface

// File: rtl/nvdla_cacc_abuf_banked.sv
// Banked CACC assembly buffer: 2-cycle registered read, write-first forwarding,
// and a hardware clear sequencer that zeroes one row of every bank per cycle.

module nvdla_cacc_abuf_bank #(
    parameter int unsigned DATA_W = 544,
    parameter int unsigned ROWS   = 32,
    parameter int unsigned RW     = 5
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [RW-1:0]     wr_row_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [RW-1:0]     rd_row_i,
    input  logic [31:0]       pwrbus_ram_pd_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] rd_data_q;
    logic              unused_pd;

    // Power-down bus is consumed by the hard macro in the RAM-compiled flow.
    assign unused_pd = ^pwrbus_ram_pd_i;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_row_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

module nvdla_cacc_abuf_banked #(
    parameter int unsigned DATA_W        = 544,
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned BANKS         = 2,
    parameter int unsigned INIT_ON_RESET = 0
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    nvdla_cacc_abuf_banked_if.slave     abuf
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LB   = $clog2(BANKS);
    localparam int unsigned BW   = (BANKS > 1) ? LB : 1;
    localparam int unsigned ROWS = DEPTH / BANKS;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e            state_q;
    logic [RW-1:0]     clr_row_q;
    logic              clr_busy_q;
    logic              init_pend_q;

    logic              rd_p1_q;
    logic [BW-1:0]     rd_bank_p1_q;
    logic              fwd_p1_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              drop_err_q;

    logic              acc_wr;
    logic              acc_rd;
    logic              collide;
    logic [BW-1:0]     wr_bank;
    logic [BW-1:0]     rd_bank;
    logic [RW-1:0]     wr_row;
    logic [RW-1:0]     rd_row;
    logic [DATA_W-1:0] bank_rdata [BANKS];

    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
        if (BANKS > 1) begin
            return BW'(a);
        end
        return '0;
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return RW'(a >> LB);
    endfunction

    // External accesses are only accepted outside the clear sequence.
    always_comb begin
        acc_wr  = abuf.abuf_wr_en & ~clr_busy_q;
        acc_rd  = abuf.abuf_rd_en & ~clr_busy_q;
        collide = acc_wr & acc_rd & (abuf.abuf_wr_addr == abuf.abuf_rd_addr);
        wr_bank = bank_of(abuf.abuf_wr_addr);
        rd_bank = bank_of(abuf.abuf_rd_addr);
        wr_row  = row_of(abuf.abuf_wr_addr);
        rd_row  = row_of(abuf.abuf_rd_addr);
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic              bwe;
        logic [RW-1:0]     bwrow;
        logic [DATA_W-1:0] bwdata;
        logic              bre;

        // During clear every bank writes zero to the sequencer row.
        always_comb begin
            bwe    = clr_busy_q | (acc_wr & (wr_bank == BW'(b)));
            bwrow  = clr_busy_q ? clr_row_q : wr_row;
            bwdata = clr_busy_q ? '0 : abuf.abuf_wr_data;
            bre    = acc_rd & (rd_bank == BW'(b));
        end

        nvdla_cacc_abuf_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .RW     (RW)
        ) u_bank (
            .clk             (nvdla_core_clk),
            .wr_en_i         (bwe),
            .wr_row_i        (bwrow),
            .wr_data_i       (bwdata),
            .rd_en_i         (bre),
            .rd_row_i        (rd_row),
            .pwrbus_ram_pd_i (abuf.pwrbus_ram_pd),
            .rd_data_o       (bank_rdata[b])
        );
    end

    // Clear sequencer.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q     <= IDLE;
            clr_row_q   <= '0;
            clr_busy_q  <= 1'b0;
            init_pend_q <= 1'(INIT_ON_RESET != 0);
        end else begin
            case (state_q)
                IDLE: begin
                    init_pend_q <= 1'b0;
                    if (abuf.abuf_clr_req || init_pend_q) begin
                        state_q    <= CLEAR;
                        clr_busy_q <= 1'b1;
                        clr_row_q  <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_row_q == LAST_ROW) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                        clr_row_q  <= '0;
                    end else begin
                        clr_row_q <= clr_row_q + RW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                    clr_row_q  <= '0;
                end
            endcase
        end
    end

    // Read pipeline control and sticky drop flag.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            rd_p1_q    <= 1'b0;
            fwd_p1_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            rd_p1_q  <= acc_rd;
            rd_vld_q <= rd_p1_q;
            if (acc_rd) begin
                fwd_p1_q <= collide;
            end
            if (rd_p1_q) begin
                rd_data_q <= fwd_p1_q ? fwd_data_q : bank_rdata[rd_bank_p1_q];
            end
            if (clr_busy_q && (abuf.abuf_wr_en || abuf.abuf_rd_en)) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    // Payload side of the pipe needs no reset; it is qualified by rd_p1_q/fwd_p1_q.
    always_ff @(posedge nvdla_core_clk) begin
        if (acc_rd) begin
            rd_bank_p1_q <= rd_bank;
        end
        if (collide) begin
            fwd_data_q <= abuf.abuf_wr_data;
        end
    end

    assign abuf.abuf_rd_data  = rd_data_q;
    assign abuf.abuf_rd_vld   = rd_vld_q;
    assign abuf.abuf_clr_busy = clr_busy_q;
    assign abuf.abuf_drop_err = drop_err_q;
endmodule

// File: doc/nvdla_cacc_abuf_banked.md
Name: nvdla_cacc_abuf_banked

Overview:
- Parametrised assembly buffer for CACC. It holds partial-sum lines in BANKS independent two-port banks, with one write port and one read port per cycle.
- Read path is registered, with an explicit read-data valid, write-first collision forwarding, and a hardware clear sequencer that zeroes the whole buffer in DEPTH/BANKS cycles.
- Sits between the CACC accumulator datapath and the delivery buffer. It succeeds the single-bank, fixed-geometry assembly buffer.

Parameters:
- DATA_W, 544, line width in bits.
- DEPTH, 64, total lines; must be a multiple of BANKS.
- BANKS, 2, number of banks; power of two, 1..8.
- AW, clog2(DEPTH), address width (derived, not overridden).
- INIT_ON_RESET, 0, if 1 the clear sequence starts automatically on reset release.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  synchronous active-low reset
- abuf_wr_en  in  1  write strobe
- abuf_wr_addr  in  AW  write address; bank = addr[log2(BANKS)-1:0], row = upper bits
- abuf_wr_data  in  DATA_W  write data
- abuf_rd_en  in  1  read strobe
- abuf_rd_addr  in  AW  read address, same mapping as write
- abuf_clr_req  in  1  single-cycle pulse; starts the clear sequence
- pwrbus_ram_pd  in  32  RAM power-down bus, passed to every bank unmodified
- abuf_rd_data  out  DATA_W  read data
- abuf_rd_vld  out  1  abuf_rd_data is valid this cycle
- abuf_clr_busy  out  1  clear sequence in progress
- abuf_drop_err  out  1  sticky: an access was dropped during clear

Behaviour:
- Clocking: single clock; synchronous active-low reset on nvdla_core_rstn.
- Reset values: abuf_rd_data=0, abuf_rd_vld=0, abuf_clr_busy=0, abuf_drop_err=0, FSM=IDLE. Bank contents are not reset.
- INIT_ON_RESET=1: first cycle after rstn rises, FSM enters CLEAR.
- Read latency is 2 cycles:
  - rd_en at cycle T; bank read at T; capture flop loads at T+1.
  - abuf_rd_data and abuf_rd_vld=1 are presented at T+2.
  - abuf_rd_vld is high exactly one cycle per accepted read.
  - abuf_rd_data holds its last value while abuf_rd_vld=0.
  - Back-to-back reads give one result per cycle.
- Write takes effect at the clock edge ending cycle T.
- Collision (wr_en and rd_en same cycle, same address): write-first. The read returns the new abuf_wr_data.
  - Forward from a registered copy of the write data and a registered address-match flag; do not add a combinational path to the outputs.
  - Same bank, different row: no interaction.
- Write at T+1 to an address read at T does not affect that read's result.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on abuf_clr_req=1, or on the first cycle out of reset when INIT_ON_RESET=1.
  - CLEAR: row counter runs 0..DEPTH/BANKS-1, one row per cycle. All banks write zero to that row in parallel.
  - CLEAR -> IDLE in the cycle after the last row is written. The counter resets to 0.
  - abuf_clr_busy is high for every cycle in CLEAR, exactly DEPTH/BANKS cycles.
- While abuf_clr_busy=1:
  - Any external wr_en or rd_en is dropped: no write, no abuf_rd_vld.
  - abuf_drop_err is set and stays set until reset.
  - abuf_clr_req is ignored; the sequence does not restart.
- Reads already in the pipeline when clear starts complete normally, returning pre-clear data.
- clr_req in the same cycle as wr_en or rd_en while IDLE: the access is accepted, then clear begins next cycle. A write accepted that cycle is later zeroed.
- Reset mid-clear: FSM returns to IDLE, busy=0, rd pipe flushed (abuf_rd_vld=0). Contents are undefined until cleared or rewritten.
- Addresses are always < DEPTH by construction; no out-of-range checking.

Test Plan:
- Reset with INIT_ON_RESET=0, DEPTH=64, BANKS=2 -> all outputs 0. Write 0xA5.. to addr 5, read addr 5 -> abuf_rd_vld pulses 2 cycles after rd_en, data 0xA5...
- Write addrs 0..63 with data=addr, then read 0..63 back-to-back -> 64 consecutive rd_vld cycles with data 0..63 in order, no bubbles.
- Same-cycle write 0x1234 and read of addr 9 (old contents 0x77) -> returns 0x1234. Read at T, write at T+1 -> returns 0x77.
- clr_req pulse after filling the buffer -> clr_busy high exactly 32 cycles. A subsequent read of every address returns 0.
- wr_en and rd_en issued during clear -> no rd_vld, contents unchanged except zeroing, drop_err=1 and held. A second clr_req mid-clear does not extend busy beyond 32 cycles.
- INIT_ON_RESET=1, BANKS=4, DEPTH=64 -> busy high 16 cycles starting the cycle after reset release. Reset asserted at clear cycle 8 -> busy=0 and rd_vld=0 next cycle.
